mul_rr_sched: RTL and testbench
===============================

Name: mul_rr_sched

Overview:
- Round-robin scheduler sharing one signed 8x8 add-shift multiplier (add_shft_mul) among NREQ requesters.
- Accepts operand pairs over a valid/ready handshake and sequences the multiplier's start/done protocol.
- Returns each 16-bit signed product on a single shared response channel, tagged with the requester index.
- Sits between the per-channel compute front-ends and the multiplier, which it instantiates internally.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; IDW = clog2(NREQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; also drives the multiplier's rst.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant; accepted in the cycle where valid and ready are both high.
- req_a  in  8*NREQ  signed multiplicand; slice i belongs to requester i.
- req_b  in  8*NREQ  signed multiplier; slice i belongs to requester i.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts the product.
- rsp_data  out  16  signed product a*b.
- rsp_id  out  IDW  index of the requester that issued the operation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, operand registers 0, mul_start=0.
- Reset mid-operation: the multiplier is reset in the same cycle and any in-flight operation is discarded without a response.
- FSM states: IDLE, START, RUN, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from rr_ptr upward, modulo NREQ.
  - req_ready[winner] is driven combinationally in that same cycle; no grant is given when req_valid is all zero.
  - At the clock edge: latch a_r = req_a[winner], b_r = req_b[winner], id_r = winner; set rr_ptr = (winner+1) mod NREQ; go to START.
- START: mul_start=1 for exactly one cycle; go to RUN.
- RUN:
  - The multiplier's done is ignored in START, because done is already high while the multiplier is idle.
  - In RUN, done is low until the multiplier counter reaches 8.
  - When done=1 in RUN: capture rsp_data = mul_c and rsp_id = id_r; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id stay stable while rsp_ready is low.
  - On rsp_ready=1: rsp_valid drops next cycle and the FSM goes to IDLE.
- a_r and b_r are held constant from accept until the product is captured, because the multiplier samples b bit-serially.
- Latency, with the accept edge ending cycle T:
  - START in T+1.
  - done observed in T+10.
  - rsp_valid first high in T+11.
  - Earliest next grant in the cycle after the response handshake.
  - Throughput is at most one operation per 12 cycles.
- Requesters hold req_valid, req_a and req_b stable until granted. A request dropped before its grant is never serviced.
- req_ready is never asserted outside IDLE.
- Arithmetic:
  - Two's complement throughout; the product fits in 16 bits for all operand pairs, including -128*-128 = +16384.
  - The scheduler does no arithmetic on the product; rsp_data is exactly mul_c.
- Single requester: rr_ptr still advances, and the same requester wins again on its next request.

Decomposition:
- Package mul_sched_pkg:
  - state enum (IDLE, START, RUN, RESP);
  - OPW=8, PRODW=16;
  - default NREQ.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, winner index, any.
- The multiplier is instantiated directly; no other sub-modules.

Test Plan:
- Single request, requester 0: a=0xBF (-65), b=0x64 (100), accept at T -> rsp_valid at T+11, rsp_data=0xE69C (-6500), rsp_id=0, busy low after the handshake.
- Fairness: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0,1; each requester's product is correct.
- Back-pressure: rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable throughout; no req_ready asserted; grant follows the handshake.
- Boundary operands:
  - -128*-128 -> 0x4000;
  - -128*127 -> 0xC080;
  - 127*127 -> 0x3F01;
  - 0*-1 -> 0x0000;
  - -1*-1 -> 0x0001.
- Reset mid-operation: rst pulsed in the 4th RUN cycle -> next cycle IDLE, rsp_valid=0, rr_ptr=0; a new request from requester 2 completes correctly in 11 cycles.
- Pointer wrap: only requester 3 valid, then requesters 0 and 3 valid -> 3 granted first, then 0 (pointer wrapped to 0), then 3.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and sizes for the round-robin multiplier scheduler.
package mul_sched_pkg;

    localparam int unsigned OPW      = 8;
    localparam int unsigned PRODW    = 16;
    localparam int unsigned NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RESP
    } state_e;

endpackage

// File: rtl/add_shft_mul.sv
// Signed 8x8 add-shift multiplier: one bit of b per cycle, eight steps after start.
// done is high while idle and again once all eight bits have been consumed.
module add_shft_mul
    import mul_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             done,
    output logic [PRODW-1:0] c
);

    logic [3:0]       cnt_q, cnt_d;
    logic [PRODW-1:0] acc_q, acc_d;
    logic [PRODW-1:0] a_ext;
    logic [PRODW-1:0] shifted;

    // Next accumulator: add a<<i for bits 0..6, subtract for the sign bit 7.
    always_comb begin
        a_ext   = {{(PRODW-OPW){a[OPW-1]}}, a};
        shifted = a_ext << cnt_q[2:0];
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        if (start) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (!cnt_q[3]) begin
            cnt_d = cnt_q + 4'd1;
            if (b[cnt_q[2:0]]) begin
                acc_d = (cnt_q[2:0] == 3'd7) ? (acc_q - shifted) : (acc_q + shifted);
            end
        end
    end

    // Step counter and accumulator registers; counter parks at 8 when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd8;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign done = cnt_q[3];
    assign c    = acc_q;

endmodule

// File: rtl/mul_rr_sched_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping modulo NREQ.
module rr_pick
    import mul_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] pos;

    // Scan from ptr upward; the first pending request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IDW'((32'(ptr_i) + k) % NREQ);
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                idx_o        = pos;
                grant_o[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one add-shift multiplier among NREQ requesters.
module mul_rr_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [PRODW-1:0]    rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [PRODW-1:0] data_q, data_d;
    logic [IDW-1:0]   rid_q, rid_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win;
    logic             any;
    logic             mul_start;
    logic             mul_done;
    logic [PRODW-1:0] mul_c;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req_i  (req_valid),
        .ptr_i  (ptr_q),
        .grant_o(grant),
        .idx_o  (win),
        .any_o  (any)
    );

    add_shft_mul u_mul (
        .clk  (clk),
        .rst  (rst),
        .start(mul_start),
        .a    (a_q),
        .b    (b_q),
        .done (mul_done),
        .c    (mul_c)
    );

    // Next-state, grant and multiplier start; done is only trusted in RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        data_d    = data_q;
        rid_d     = rid_q;
        req_ready = '0;
        mul_start = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (any) begin
                    a_d     = req_a[32'(win)*OPW +: OPW];
                    b_d     = req_b[32'(win)*OPW +: OPW];
                    id_d    = win;
                    ptr_d   = (32'(win) == NREQ - 1) ? '0 : win + IDW'(1);
                    state_d = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (mul_done) begin
                    data_d  = mul_c;
                    rid_d   = id_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, operand and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            data_q  <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            data_q  <= data_d;
            rid_q   <= rid_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = data_q;
    assign rsp_id    = rid_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// Directed, table-driven bench for mul_rr_sched with NREQ=4.
module tb_mul_rr_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int compared;
    int mismatched;

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] fair_exp[4];

    mul_rr_sched #(
        .NREQ(4),
        .IDW (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_id   (rsp_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
    endtask

    // Issue from an IDLE cycle with rsp_ready=1; checks grant, latency, response, drop.
    task automatic op(input logic [3:0] mask, input int exp_id, input logic [15:0] exp_data,
                      input bit hold, input string tag);
        int lat;
        bit bad_rdy;
        logic [3:0] exp_grant;
        exp_grant = 4'b0001 << exp_id;
        req_valid = mask;
        #1;
        check({tag, "_grant"}, 32'(req_ready), 32'(exp_grant));
        step();
        if (!hold) req_valid = '0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 1;
        bad_rdy = 1'b0;
        while (!rsp_valid && lat < 40) begin
            if (req_ready != '0) bad_rdy = 1'b1;
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd11);
        check({tag, "_no_ready_busy"}, 32'(bad_rdy), 32'd0);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        step();
        check({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;
        compared   = 0;
        mismatched = 0;
        rsp_ready  = 1'b1;
        req_a      = '0;
        req_b      = '0;

        vecs[0] = '{0, 8'hBF, 8'h64, 16'hE69C};
        vecs[1] = '{1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{2, 8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{3, 8'h7F, 8'h7F, 16'h3F01};
        vecs[4] = '{0, 8'h00, 8'hFF, 16'h0000};
        vecs[5] = '{1, 8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{2, 8'h05, 8'hFD, 16'hFFF1};
        vecs[7] = '{3, 8'h0C, 8'h0A, 16'h0078};

        do_reset();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single-requester vectors, including boundary operands.
        for (int i = 0; i < 8; i++) begin
            set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
            op(4'b0001 << vecs[i].id, vecs[i].id, vecs[i].prod, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Fairness: all four held valid, grant order 0,1,2,3,0,1.
        do_reset();
        set_ops(0, 8'd3,   8'd4);   fair_exp[0] = 16'h000C;
        set_ops(1, 8'hF9,  8'd9);   fair_exp[1] = 16'hFFC1;
        set_ops(2, 8'd100, 8'hFE);  fair_exp[2] = 16'hFF38;
        set_ops(3, 8'hCE,  8'hCE);  fair_exp[3] = 16'h09C4;
        for (int k = 0; k < 6; k++) begin
            op(4'hF, k % 4, fair_exp[k % 4], 1'b1, $sformatf("fair%0d", k));
        end
        req_valid = '0;
        step();

        // Back-pressure: response held for 5 cycles with another request pending.
        set_ops(1, 8'hFD, 8'd7);
        set_ops(0, 8'd2, 8'd2);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            step();
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd11);
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_data%0d", i), 32'(rsp_data), 32'hFFEB);
            check($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd1);
            check($sformatf("bp_noready%0d", i), 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        check("bp_rsp_drop", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();
        check("bp_idle", 32'(busy), 32'd0);

        // Reset in the 4th RUN cycle discards the operation.
        set_ops(1, 8'd9, 8'd9);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen = 1'b1;
            step();
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        req_valid = 4'hF;
        #1;
        check("mid_rst_ptr0", 32'(req_ready), 32'b0001);
        set_ops(2, 8'd25, 8'hFC);
        op(4'b0100, 2, 16'hFF9C, 1'b0, "post_rst");

        // Pointer wrap: 3, then 0 after wrap, then 3.
        do_reset();
        set_ops(3, 8'hF7, 8'd11);
        set_ops(0, 8'd15, 8'd15);
        op(4'b1000, 3, 16'hFF9D, 1'b0, "wrap_a");
        op(4'b1001, 0, 16'h00E1, 1'b0, "wrap_b");
        op(4'b1001, 3, 16'hFF9D, 1'b0, "wrap_c");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
